// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 opcode encodings (MDU_MUL .. MDU_REMU)
//   - FSM state encoding (MDU_IDLE, MDU_CALC, MDU_FIN)
//   - mdu_cnt_w(): width of the iteration counter for a given XLEN
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  // Counter must hold XLEN itself (loaded on accept, counted down to 0).
  function automatic int mdu_cnt_w(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: restoring-divide iteration datapath on unsigned magnitudes.
//   clk, rst_n       : clock, async active-low reset
//   load             : latch dividend into quotient reg, clear remainder
//   step             : one restoring iteration (shift, trial subtract, set q bit)
//   dividend/divisor : unsigned operand magnitudes (divisor must be non-zero)
//   quotient/remainder : results, valid after XLEN steps
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the remainder each step while the new quotient bit enters at LSB.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {remainder, quotient[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // remainder < divisor is invariant, so diff MSB is exactly the borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
    end else if (step) begin
      if (!diff[XLEN]) begin
        remainder <= diff[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= shifted[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative RV32M multiply/divide unit on the shared result bus.
//   clk_in, rst_n_in : clock, async active-low reset
//   rdy_in           : global enable, low freezes every register
//   clear_signal     : mispredict flush, aborts in-flight op
//   cal_signal       : RS presents opcode/lhs/rhs/tag this cycle
//   ready_out        : idle, can accept
//   done_result/value_result/tag_result : one-cycle result broadcast
// Build option: MDU_FAST_MUL_EN -- multiplies resolve combinationally at
// accept (like the special cases); otherwise shift-add over XLEN steps.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int ROB_WIDTH = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 cal_signal,
  input  logic [2:0]           opcode,
  input  logic [XLEN-1:0]      lhs,
  input  logic [XLEN-1:0]      rhs,
  input  logic [ROB_WIDTH-1:0] tag,
  output logic                 ready_out,
  output logic                 done_result,
  output logic [XLEN-1:0]      value_result,
  output logic [ROB_WIDTH-1:0] tag_result
);

  localparam int CW = mdu_cnt_w(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q;
  logic [ROB_WIDTH-1:0] tag_q;
  logic                 neg_q;
  logic [2*XLEN-1:0]    acc_q;
  logic [XLEN-1:0]      mcand_q;

  logic                 done_d;
  logic [XLEN-1:0]      value_d;
  logic [ROB_WIDTH-1:0] tagr_d;
  logic                 load_c, step_c;

  // ---------------- operand decode ----------------
  logic            is_div, signed_a, signed_b, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            spec_hit;
  logic [XLEN-1:0] spec_val;

  assign is_div   = opcode[2];
  assign signed_a = !(opcode == MDU_MULHU || opcode == MDU_DIVU || opcode == MDU_REMU);
  assign signed_b = signed_a && (opcode != MDU_MULHSU);
  assign a_neg    = signed_a & lhs[XLEN-1];
  assign b_neg    = signed_b & rhs[XLEN-1];
  assign a_mag    = a_neg ? -lhs : lhs;
  assign b_mag    = b_neg ? -rhs : rhs;
  // Remainder follows the dividend; product/quotient follow the sign xor.
  assign neg_in   = (is_div & opcode[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod, fprod_c;
  assign fprod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fprod_c = neg_in ? -fprod : fprod;
`endif

  // Ops resolved at accept without iterating. opcode[1] picks REM* vs DIV*.
  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    if (is_div && rhs == '0) begin
      spec_hit = 1'b1;
      spec_val = opcode[1] ? lhs : '1;
    end else if (!opcode[0] && is_div && lhs == INT_MIN && rhs == '1) begin
      spec_hit = 1'b1;
      spec_val = opcode[1] ? '0 : lhs;
    end
`ifdef MDU_FAST_MUL_EN
    else if (!is_div) begin
      spec_hit = 1'b1;
      spec_val = (opcode == MDU_MUL) ? fprod_c[XLEN-1:0] : fprod_c[2*XLEN-1:XLEN];
    end
`endif
  end

  // ---------------- datapaths ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign prod    = neg_q ? -acc_q : acc_q;

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .load      (rdy_in & load_c),
    .step      (rdy_in & step_c),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  assign ready_out = (state_q == MDU_IDLE);

  // ---------------- FSM next-state / outputs ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    value_d = value_result;
    tagr_d  = tag_result;
    load_c  = 1'b0;
    step_c  = 1'b0;
    if (clear_signal) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (cal_signal) begin
            if (spec_hit) begin
              done_d  = 1'b1;
              value_d = spec_val;
              tagr_d  = tag;
            end else begin
              load_c  = 1'b1;
              cnt_d   = CW'(XLEN);
              state_d = MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          step_c = 1'b1;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = MDU_FIN;
        end
        MDU_FIN: begin
          done_d  = 1'b1;
          tagr_d  = tag_q;
          state_d = MDU_IDLE;
          case (op_q)
            MDU_MUL:                       value_d = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: value_d = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:             value_d = neg_q ? -quo : quo;
            default:                       value_d = neg_q ? -rem : rem;
          endcase
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= MDU_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      mcand_q      <= '0;
      done_result  <= 1'b0;
      value_result <= '0;
      tag_result   <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_result  <= done_d;
      value_result <= value_d;
      tag_result   <= tagr_d;
      if (load_c) begin
        op_q    <= opcode;
        tag_q   <= tag;
        neg_q   <= neg_in;
        mcand_q <= a_mag;
        acc_q   <= {{XLEN{1'b0}}, b_mag};
      end else if (step_c) begin
        acc_q   <= {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit. A driver pushes the expected
// value/tag/completion cycle into a queue; a monitor pops on done_result.
module tb_mdu_unit;
  localparam int XLEN = 32;
  localparam int RW   = 4;
  localparam int ITER = XLEN + 1;  // edges after the accept edge until done registers
`ifdef MDU_FAST_MUL_EN
  localparam int MULX = 0;
`else
  localparam int MULX = ITER;
`endif

  logic            clk, rst_n, rdy, clear, cal;
  logic [2:0]      opcode;
  logic [XLEN-1:0] lhs, rhs;
  logic [RW-1:0]   tag;
  logic            ready_out, done_result;
  logic [XLEN-1:0] value_result;
  logic [RW-1:0]   tag_result;

  mdu_unit #(.ROB_WIDTH(RW), .XLEN(XLEN)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear_signal(clear),
    .cal_signal(cal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag),
    .ready_out(ready_out), .done_result(done_result),
    .value_result(value_result), .tag_result(tag_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] val;
    logic [RW-1:0]   tg;
    int              cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_result) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got value %0h tag %0h, expected no result", value_result, tag_result);
      end else begin
        e = sb.pop_front();
        chk("value", value_result, e.val);
        chk("tag", tag_result, e.tg);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RW-1:0] t, input logic [XLEN-1:0] ev, input int extra,
                       input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready_out && n < 200) begin
      cal = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got ready_out 0, expected 1");
    end
    cal = 1'b1; opcode = op; lhs = a; rhs = b; tag = t;
    if (push) begin
      e.val = ev; e.tg = t; e.cyc = cyc + 1 + extra;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cal = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; cal = 1'b0;
    opcode = '0; lhs = '0; rhs = '0; tag = '0;
    #12;
    chk("rst_ready", ready_out, 1);
    chk("rst_done", done_result, 0);
    chk("rst_value", value_result, 0);
    chk("rst_tag", tag_result, 0);
    @(negedge clk) rst_n = 1'b1;

    // MUL 7 * -3 with busy window check
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 4'd5, 32'hFFFFFFEB, MULX, 1);
`ifndef MDU_FAST_MUL_EN
    for (int i = 0; i < ITER; i++) begin
      @(negedge clk);
      cal = 1'b0;
      chk("mul_busy", ready_out, 0);
    end
    @(negedge clk);
    chk("mul_ready_after", ready_out, 1);
`else
    idle(3);
`endif

    // multiplies and divides
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'hFFFFFFFE, MULX, 1);
    issue(3'd2, 32'hFFFFFFFF, 32'd2,        4'd2, 32'hFFFFFFFF, MULX, 1);
    issue(3'd1, 32'h80000000, 32'h80000000, 4'd3, 32'h40000000, MULX, 1);
    issue(3'd4, 32'hFFFFFFF9, 32'd2,        4'd4, 32'hFFFFFFFD, ITER, 1);
    issue(3'd6, 32'hFFFFFFF9, 32'd2,        4'd6, 32'hFFFFFFFF, ITER, 1);
    issue(3'd5, 32'd100,      32'd7,        4'd7, 32'd14,       ITER, 1);
    issue(3'd7, 32'd100,      32'd7,        4'd8, 32'd2,        ITER, 1);
    issue(3'd6, 32'd7,        32'hFFFFFFFE, 4'd9, 32'd1,        ITER, 1);
    issue(3'd4, 32'd7,        32'hFFFFFFFE, 4'd10, 32'hFFFFFFFD, ITER, 1);
    idle(ITER + 3);

    // back-to-back special cases
    issue(3'd5, 32'd5, 32'd0, 4'd11, 32'hFFFFFFFF, 0, 1);
    c0 = cyc;
    issue(3'd6, 32'd5, 32'd0, 4'd12, 32'd5, 0, 1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 4'd13, 32'h80000000, 0, 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 4'd14, 32'd0, 0, 1);
    chk("b2b_accept", cyc - c0, 3);
    idle(3);

    // flush on cycle 10 of a DIV
    issue(3'd4, 32'd100, 32'd7, 4'd15, 32'd0, ITER, 0);
    idle(9);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("flush_ready", ready_out, 1);
    chk("flush_done", done_result, 0);
    idle(ITER + 4);
    issue(3'd5, 32'd9, 32'd3, 4'd6, 32'd3, ITER, 1);
    idle(ITER + 3);

    // four stalled edges mid-CALC
    issue(3'd4, 32'hFFFFFF9C, 32'd7, 4'd11, 32'hFFFFFFF2, ITER + 4, 1);
    idle(10);
    @(negedge clk);
    rdy = 1'b0;
    repeat (4) @(negedge clk);
    rdy = 1'b1;
    idle(ITER + 3);

    // async reset mid-CALC
    issue(3'd5, 32'd50, 32'd5, 4'd2, 32'd0, ITER, 0);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready_out, 1);
    chk("arst_done", done_result, 0);
    chk("arst_value", value_result, 0);
    chk("arst_tag", tag_result, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    issue(3'd7, 32'd100, 32'd7, 4'd1, 32'd2, ITER, 1);
    idle(ITER + 4);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
